// File: rtl/issue_stage_pkg.sv
// Shared definitions for the issue stage: functional-unit codes, forwarding
// encoding, the "result arrives next" scoreboard row and the FSM states.
package issue_stage_pkg;

  localparam logic [1:0] UNIT_AM   = 2'b00;
  localparam logic [1:0] UNIT_MEM  = 2'b01;
  localparam logic [1:0] UNIT_MULT = 2'b10;

  // Operand source 000 selects the register file.
  localparam logic [2:0] FWD_NONE = 3'b000;

  // Scoreboard row one-hot meaning "result is on the forwarding path next cycle".
  localparam logic [4:0] ROW_NEXT = 5'b00001;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

endpackage

// File: rtl/issue_operand_check.sv
// Per-operand readiness check against the scoreboard lookup result.
// A source is ready when unused, r0, not pending, or pending with its result
// arriving next cycle (then it is forwarded from the producing unit).
module issue_operand_check
  import issue_stage_pkg::*;
(
  input  logic [4:0] i_addr,
  input  logic       i_used,
  input  logic       i_pending,
  input  logic [1:0] i_unit,
  input  logic [4:0] i_row,
  output logic       o_ready,
  output logic [2:0] o_fwd
);

  logic w_needs_check;
  logic w_can_forward;

  assign w_needs_check = i_used && (i_addr != 5'd0) && i_pending;
  assign w_can_forward = (i_row == ROW_NEXT);

  // Readiness and forwarding select for one operand
  always_comb begin
    o_ready = 1'b1;
    o_fwd   = FWD_NONE;
    if (w_needs_check) begin
      if (w_can_forward) begin
        o_fwd = {1'b1, i_unit};
      end else begin
        o_ready = 1'b0;
      end
    end
  end

endmodule

// File: rtl/issue_stage.sv
// Single-entry issue stage: holds one decoded instruction, checks RAW, WAW
// and writeback-slot hazards against the scoreboard, claims the destination
// and dispatches to AluMisc, Mem or Mult.
// Optional build macro ISSUE_STALL_COUNTERS_EN adds saturating stall counters.
module issue_stage
  import issue_stage_pkg::*;
#(
  parameter int PAYLOAD_W   = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [PAYLOAD_W-1:0] id_payload,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic [4:0]           id_rd,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 id_writes_rd,
  input  logic [1:0]           id_unit,
  input  logic                 flush,
  output logic [4:0]           iss_ass_addr_a,
  output logic [4:0]           iss_ass_addr_b,
  input  logic                 iss_ass_pending_a,
  input  logic [1:0]           iss_ass_unit_a,
  input  logic [4:0]           iss_ass_row_a,
  input  logic                 iss_ass_pending_b,
  input  logic [1:0]           iss_ass_unit_b,
  input  logic [4:0]           iss_ass_row_b,
  input  logic                 dst_pending,
  input  logic [31:0]          sb_haz_column,
  output logic [4:0]           writeaddr,
  output logic [1:0]           registerunit,
  output logic                 enablewrite,
  output logic                 ex_valid_am,
  output logic                 ex_valid_mem,
  output logic                 ex_valid_mult,
  output logic [PAYLOAD_W-1:0] ex_payload,
  output logic [2:0]           ex_fwd_a,
  output logic [2:0]           ex_fwd_b
`ifdef ISSUE_STALL_COUNTERS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_raw_cnt,
  output logic [STALL_CNT_W-1:0] stall_waw_cnt,
  output logic [STALL_CNT_W-1:0] stall_wb_cnt
`endif
);

  state_t r_state;
  state_t w_state_next;

  // Holding register
  logic [PAYLOAD_W-1:0] r_payload;
  logic [4:0]           r_rs;
  logic [4:0]           r_rt;
  logic [4:0]           r_rd;
  logic                 r_uses_rs;
  logic                 r_uses_rt;
  logic                 r_writes_rd;
  logic [1:0]           r_unit;

  // Dispatch registers
  logic                 r_ex_valid_am;
  logic                 r_ex_valid_mem;
  logic                 r_ex_valid_mult;
  logic [PAYLOAD_W-1:0] r_ex_payload;
  logic [2:0]           r_ex_fwd_a;
  logic [2:0]           r_ex_fwd_b;

  logic       w_held;
  logic       w_ready_a;
  logic       w_ready_b;
  logic [2:0] w_fwd_a;
  logic [2:0] w_fwd_b;
  logic       w_raw;
  logic       w_waw;
  logic       w_wb;
  logic       w_go;
  logic       w_id_ready;
  logic       w_capture;

  issue_operand_check u_check_a (
    .i_addr    (r_rs),
    .i_used    (r_uses_rs),
    .i_pending (iss_ass_pending_a),
    .i_unit    (iss_ass_unit_a),
    .i_row     (iss_ass_row_a),
    .o_ready   (w_ready_a),
    .o_fwd     (w_fwd_a)
  );

  issue_operand_check u_check_b (
    .i_addr    (r_rt),
    .i_used    (r_uses_rt),
    .i_pending (iss_ass_pending_b),
    .i_unit    (iss_ass_unit_b),
    .i_row     (iss_ass_row_b),
    .o_ready   (w_ready_b),
    .o_fwd     (w_fwd_b)
  );

  assign w_held = (r_state == ST_HELD);
  assign w_raw  = !(w_ready_a && w_ready_b);
  assign w_waw  = (r_rd != 5'd0) && dst_pending;
  assign w_wb   = r_writes_rd && (|sb_haz_column);
  assign w_go   = w_held && !flush && !w_raw && !w_waw && !w_wb;

  assign iss_ass_addr_a = w_held ? r_rs : 5'd0;
  assign iss_ass_addr_b = w_held ? r_rt : 5'd0;
  assign writeaddr      = w_held ? r_rd : 5'd0;
  assign registerunit   = r_unit;
  assign enablewrite    = w_go && r_writes_rd && (r_rd != 5'd0);
  assign id_ready       = w_id_ready;

  assign ex_valid_am    = r_ex_valid_am;
  assign ex_valid_mem   = r_ex_valid_mem;
  assign ex_valid_mult  = r_ex_valid_mult;
  assign ex_payload     = r_ex_payload;
  assign ex_fwd_a       = r_ex_fwd_a;
  assign ex_fwd_b       = r_ex_fwd_b;

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_EMPTY;
    else        r_state <= w_state_next;
  end

  // Next state and decode handshake; a flush also refuses new decode input
  always_comb begin
    w_state_next = r_state;
    w_id_ready   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_id_ready = !flush;
        if (id_valid && !flush) w_state_next = ST_HELD;
      end
      ST_HELD: begin
        w_id_ready = w_go;
        if (flush)     w_state_next = ST_EMPTY;
        else if (w_go) w_state_next = id_valid ? ST_HELD : ST_EMPTY;
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  assign w_capture = id_valid && w_id_ready;

  // Capture decode output; the illegal unit code is folded onto Mult here
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_payload   <= '0;
      r_rs        <= 5'd0;
      r_rt        <= 5'd0;
      r_rd        <= 5'd0;
      r_uses_rs   <= 1'b0;
      r_uses_rt   <= 1'b0;
      r_writes_rd <= 1'b0;
      r_unit      <= UNIT_AM;
    end else if (w_capture) begin
      r_payload   <= id_payload;
      r_rs        <= id_rs;
      r_rt        <= id_rt;
      r_rd        <= id_rd;
      r_uses_rs   <= id_uses_rs;
      r_uses_rt   <= id_uses_rt;
      r_writes_rd <= id_writes_rd;
      r_unit      <= (id_unit == 2'b11) ? UNIT_MULT : id_unit;
    end
  end

  // Dispatch: one-cycle valid pulse per issue, payload/forwarding held until next issue
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ex_valid_am   <= 1'b0;
      r_ex_valid_mem  <= 1'b0;
      r_ex_valid_mult <= 1'b0;
      r_ex_payload    <= '0;
      r_ex_fwd_a      <= FWD_NONE;
      r_ex_fwd_b      <= FWD_NONE;
    end else begin
      r_ex_valid_am   <= w_go && (r_unit == UNIT_AM);
      r_ex_valid_mem  <= w_go && (r_unit == UNIT_MEM);
      r_ex_valid_mult <= w_go && (r_unit == UNIT_MULT);
      if (w_go) begin
        r_ex_payload <= r_payload;
        r_ex_fwd_a   <= w_fwd_a;
        r_ex_fwd_b   <= w_fwd_b;
      end
    end
  end

`ifdef ISSUE_STALL_COUNTERS_EN
  logic w_cnt_raw;
  logic w_cnt_waw;
  logic w_cnt_wb;

  // Attribute each blocked cycle to exactly one cause: RAW, then WAW, then writeback slot
  assign w_cnt_raw = w_held && !flush && w_raw;
  assign w_cnt_waw = w_held && !flush && !w_raw && w_waw;
  assign w_cnt_wb  = w_held && !flush && !w_raw && !w_waw && w_wb;

  // Saturating stall counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_raw_cnt <= '0;
      stall_waw_cnt <= '0;
      stall_wb_cnt  <= '0;
    end else begin
      if (w_cnt_raw && !(&stall_raw_cnt)) stall_raw_cnt <= stall_raw_cnt + 1'b1;
      if (w_cnt_waw && !(&stall_waw_cnt)) stall_waw_cnt <= stall_waw_cnt + 1'b1;
      if (w_cnt_wb  && !(&stall_wb_cnt))  stall_wb_cnt  <= stall_wb_cnt + 1'b1;
    end
  end
`else
  logic [STALL_CNT_W-1:0] w_unused_stall_cnt;
  assign w_unused_stall_cnt = '0;
`endif

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Single-entry issue stage between decode and the three functional units: AluMisc, Mem and Mult.
- Holds one decoded instruction and queries the register scoreboard for RAW hazards, WAW hazards and writeback-slot conflicts.
- Stalls decode while a hazard exists.
- On issue, claims the destination register in the scoreboard and dispatches the instruction, with forwarding selects, to the selected unit.

Parameters:
- PAYLOAD_W, 32, width of the opaque instruction payload carried to the execution units.
- STALL_CNT_W, 16, width of the stall counters (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  async, active-low
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  issue stage can accept this cycle
- id_payload  in  PAYLOAD_W  instruction payload
- id_rs  in  5  source register A
- id_rt  in  5  source register B
- id_rd  in  5  destination register
- id_uses_rs  in  1  operand A is read
- id_uses_rt  in  1  operand B is read
- id_writes_rd  in  1  instruction writes id_rd
- id_unit  in  2  00 AluMisc, 01 Mem, 10 Mult; 11 is illegal and treated as Mult
- flush  in  1  squash the held instruction
- iss_ass_addr_a  out  5  scoreboard lookup address A (held rs)
- iss_ass_addr_b  out  5  scoreboard lookup address B (held rt)
- iss_ass_pending_a  in  1  register A status
- iss_ass_unit_a  in  2  register A unit
- iss_ass_row_a  in  5  register A stage one-hot
- iss_ass_pending_b  in  1  register B status
- iss_ass_unit_b  in  2  register B unit
- iss_ass_row_b  in  5  register B stage one-hot
- dst_pending  in  1  scoreboard pending bit of the held rd
- sb_haz_column  in  32  writeback-slot column for registerunit
- writeaddr  out  5  register claimed
- registerunit  out  2  unit of the held instruction (combinational from the holding register)
- enablewrite  out  1  claim strobe, high only in the issuing cycle
- ex_valid_am  out  1  dispatch pulse to AluMisc
- ex_valid_mem  out  1  dispatch pulse to Mem
- ex_valid_mult  out  1  dispatch pulse to Mult
- ex_payload  out  PAYLOAD_W  dispatched payload
- ex_fwd_a  out  3  operand A source: {forward, unit[1:0]}; 000 means register file
- ex_fwd_b  out  3  operand B source: {forward, unit[1:0]}; 000 means register file

Behaviour:
- FSM states: EMPTY, HELD.
  - EMPTY: id_ready=1; id_valid captures the instruction into the holding register and moves to HELD.
  - HELD: evaluates `go` combinationally each cycle.
    - `go` asserted: issue happens this cycle. enablewrite=id_writes_rd&&(rd!=0). The ex_* registers load on the next edge.
    - Simultaneous refill: id_ready=go, so an issue and a capture in the same cycle stay in HELD with zero bubble.
    - `go` deasserted: hold all state; id_ready=0.
- Source register readiness: per used source reg r:
  - r==0 is always ready.
  - !pending is ready, with fwd=000.
  - pending && row==5'b00001 is ready with forwarding, fwd={1,unit}.
  - Otherwise RAW stall.
- WAW: held rd!=0 && dst_pending -> stall.
- Structural: id_writes_rd && |sb_haz_column -> stall (writeback slot already claimed).
- go = HELD && !flush && every source ready && !WAW && !structural.
- flush:
  - In HELD: return to EMPTY, no enablewrite, no ex_valid.
  - flush && id_valid in the same cycle: the new instruction is dropped and id_ready=0.
- Dispatch outputs: registered; exactly one ex_valid_* high for one cycle after go, selected by unit.
  - ex_payload and ex_fwd_* are held until the next dispatch.
- Reset (async): state=EMPTY; all ex_valid_*=0; ex_payload=0; ex_fwd_*=000; enablewrite=0; id_ready=1 once reset is released.
  - Reset mid-stall discards the held instruction.
- When EMPTY, iss_ass_addr_a, iss_ass_addr_b and writeaddr drive 0.

Optional Feature:
- Macro: ISSUE_STALL_COUNTERS_EN.
- When defined, adds three saturating STALL_CNT_W outputs:
  - stall_raw_cnt
  - stall_waw_cnt
  - stall_wb_cnt
- Each increments once per HELD cycle in which its cause blocks go. Priority when several causes hold: RAW > WAW > wb. Reset value is 0.
- When undefined, the ports and the logic are absent.

Decomposition:
- Shared package holds:
  - unit codes UNIT_AM=2'b00, UNIT_MEM=2'b01, UNIT_MULT=2'b10
  - FWD_NONE=3'b000
  - FSM state encodings
  - the ROW_NEXT=5'b00001 constant
- One sub-module, issue_operand_check: evaluates per operand (addr, used, pending, unit, row) to (ready, fwd). Instantiated twice.

Test Plan:
- Reset, then id_valid with rs=3, rt=4, both not pending, unit=00, rd=5 -> HELD next cycle; enablewrite=1 with writeaddr=5, registerunit=00; ex_valid_am=1 one cycle later; fwd_a=fwd_b=000.
- Held rs=7, pending_a=1, unit_a=10, row_a=00100 -> stall (id_ready=0) while row is 00100 or 00010. At row 00001, issue with ex_fwd_a=3'b110.
- sb_haz_column=32'h0000_0400 with id_writes_rd=1 -> no enablewrite and no ex_valid. Column cleared -> issue the same cycle.
- Held rd=9 with dst_pending=1 -> WAW stall. A source of r0 with pending_a=1 never stalls. rd=0 issues with enablewrite=0.
- Back-to-back: two valid instructions, no hazards -> dispatch on consecutive cycles with id_ready held at 1.
- flush asserted during a RAW stall -> EMPTY, no ex_valid, no enablewrite. Async reset during HELD -> all outputs at reset values immediately.
